cpu_seq_ctrl: RTL
=================

Name: cpu_seq_ctrl

Overview:
Run/halt/single-step sequencer for the CPU15 four-phase core. It replaces free-running phase generation with one-hot phase enables (fetch, decode, execute, write-back) gated by a run-control state machine. Sources of halt: host request, single-step completion, HLT opcode, and a PC breakpoint. It sits between the top-level clock and the fetch/decode/exec/write-back stages and counts retired instructions.

Parameters:
PHASE_LEN, 1, CLK cycles per phase (legal range 1..15)
HLT_OP, 4'b1111, opcode that halts the core after its write-back

Ports:
CLK  input  1  system clock
RESET_N  input  1  reset, asynchronous, active-low
RUN_REQ  input  1  level; start free-running from HALT
STEP_REQ  input  1  level; execute exactly one instruction from HALT
HALT_REQ  input  1  pulse or level; stop at next instruction boundary
OP_CODE  input  4  opcode of the instruction currently in flight (valid from DC onward)
P_COUNT  input  8  program counter (next fetch address)
BRK_EN  input  1  breakpoint enable
BRK_ADDR  input  8  breakpoint address
EN_FT  output  1  fetch phase enable pulse
EN_DC  output  1  decode phase enable pulse
EN_EX  output  1  execute phase enable pulse
EN_WB  output  1  write-back phase enable pulse
RUNNING  output  1  high in any phase state
HALT_CAUSE  output  2  0 reset, 1 host/step, 2 HLT opcode, 3 breakpoint
INSTR_CNT  output  16  retired-instruction counter
CYCLE_CNT  output  32  active-cycle counter (see Optional Feature)

Behaviour:
- Reset (async, RESET_N=0): state HALT, all EN_* 0, RUNNING 0, HALT_CAUSE 0, INSTR_CNT 0, CYCLE_CNT 0, step/halt latches 0, first-instr flag 0.
- States: HALT, FT, DC, EX, WB. Outputs registered.
- Each phase state lasts PHASE_LEN cycles. Its EN_* is a 1-cycle pulse in the first cycle of the phase. At most one EN_* is high in any cycle.
- HALT exit: HALT_REQ high blocks exit. Otherwise STEP_REQ high sets step mode and goes to FT. Otherwise RUN_REQ high sets run mode and goes to FT. STEP has priority over RUN. Exit sets the first-instr flag. Transition takes 1 cycle; EN_FT pulses in the first FT cycle.
- HALT_REQ seen in any phase state sets a sticky latch. The latch clears on entering HALT.
- Last cycle of WB: INSTR_CNT increments, wrapping 0xFFFF to 0x0000. Then the next state is chosen in priority order:
  1. Step mode: HALT, cause 1.
  2. Halt latch set: HALT, cause 1.
  3. OP_CODE==HLT_OP: HALT, cause 2.
  4. BRK_EN and P_COUNT==BRK_ADDR and first-instr flag clear: HALT, cause 3.
  5. Otherwise: FT, and the first-instr flag clears.
- The breakpoint is suppressed for the first instruction after leaving HALT. Resuming at a breakpoint address therefore proceeds.
- A breakpoint never aborts an instruction mid-phase. Halt occurs only at WB completion.
- HALT_CAUSE holds its value until the next halt entry.
- Level RUN_REQ or STEP_REQ still high while in HALT re-triggers. Callers drop them after RUNNING rises.
- Reset asserted mid-phase: immediate HALT, no partial enables. The instruction is not counted.

Optional Feature:
SEQ_CYCLE_CNT_EN. When defined, CYCLE_CNT increments by 1 each CLK while RUNNING=1, wraps at 2^32, and is cleared only by reset. When undefined, CYCLE_CNT is tied to 0 and no counter logic exists. All other behaviour is identical in both builds.

Test Plan:
- Reset, then STEP_REQ pulsed 1 cycle (PHASE_LEN=1) -> EN_FT, EN_DC, EN_EX, EN_WB in 4 consecutive cycles; HALT follows; INSTR_CNT=1; HALT_CAUSE=1.
- RUN_REQ with OP_CODE=4'h3, 10 instructions, then OP_CODE=4'hF -> halts after the 11th WB; INSTR_CNT=11; HALT_CAUSE=2.
- Run with BRK_EN=1, BRK_ADDR=8'h05, PC incrementing from 0 -> halts when P_COUNT=05 after WB, before EN_FT, with HALT_CAUSE=3. RUN_REQ again -> fetch at 05 proceeds, no immediate re-halt.
- HALT_REQ 1-cycle pulse during EX -> current WB completes; HALT_CAUSE=1; no further EN_FT.
- RESET_N low during DC -> all EN_* 0 and RUNNING 0 within the same cycle; INSTR_CNT=0.
- PHASE_LEN=3 with SEQ_CYCLE_CNT_EN defined, one step -> EN pulses 3 cycles apart; CYCLE_CNT=12; INSTR_CNT wraps FFFF->0000 when preloaded by running 65536 HLT-free steps.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: run/halt/single-step sequencer producing one-hot phase enables for the four-phase core.
// Optional macro SEQ_CYCLE_CNT_EN enables the active-cycle counter on CYCLE_CNT (tied to 0 otherwise).
module cpu_seq_ctrl #(
  parameter int         PHASE_LEN = 1,
  parameter logic [3:0] HLT_OP    = 4'b1111
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        RUN_REQ,
  input  logic        STEP_REQ,
  input  logic        HALT_REQ,
  input  logic [3:0]  OP_CODE,
  input  logic [7:0]  P_COUNT,
  input  logic        BRK_EN,
  input  logic [7:0]  BRK_ADDR,
  output logic        EN_FT,
  output logic        EN_DC,
  output logic        EN_EX,
  output logic        EN_WB,
  output logic        RUNNING,
  output logic [1:0]  HALT_CAUSE,
  output logic [15:0] INSTR_CNT,
  output logic [31:0] CYCLE_CNT
);
  typedef enum logic [2:0] {HALT, FT, DC, EX, WB} state_t;
  state_t      state, state_nxt;
  logic [3:0]  ph_cnt;
  logic        step_mode, halt_lat, first_instr;
  logic        last, exit_halt, wb_done;
  logic [1:0]  cause_nxt;
  // next-state selection: phases advance after PHASE_LEN cycles, halt decisions only at WB completion
  always_comb begin
    state_nxt = state;
    cause_nxt = HALT_CAUSE;
    last      = ph_cnt == 4'(PHASE_LEN - 1);
    exit_halt = !HALT_REQ && (STEP_REQ || RUN_REQ);
    wb_done   = state == WB && last;
    case (state)
      HALT: state_nxt = exit_halt ? FT : HALT;
      FT:   state_nxt = last ? DC : FT;
      DC:   state_nxt = last ? EX : DC;
      EX:   state_nxt = last ? WB : EX;
      WB:
        if (last) begin
          if (step_mode || halt_lat || HALT_REQ) begin
            state_nxt = HALT;
            cause_nxt = 2'd1;
          end else if (OP_CODE == HLT_OP) begin
            state_nxt = HALT;
            cause_nxt = 2'd2;
          end else if (BRK_EN && P_COUNT == BRK_ADDR && !first_instr) begin
            state_nxt = HALT;
            cause_nxt = 2'd3;
          end else begin
            state_nxt = FT;
          end
        end
      default: state_nxt = HALT;
    endcase
  end
  // state, registered enables, run-control latches and retired-instruction counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= HALT;
      ph_cnt      <= '0;
      EN_FT       <= 1'b0;
      EN_DC       <= 1'b0;
      EN_EX       <= 1'b0;
      EN_WB       <= 1'b0;
      RUNNING     <= 1'b0;
      HALT_CAUSE  <= 2'd0;
      INSTR_CNT   <= '0;
      step_mode   <= 1'b0;
      halt_lat    <= 1'b0;
      first_instr <= 1'b0;
    end else begin
      state       <= state_nxt;
      ph_cnt      <= (state_nxt != state || state == HALT) ? 4'd0 : ph_cnt + 4'd1;
      EN_FT       <= state_nxt == FT && state != FT;
      EN_DC       <= state_nxt == DC && state != DC;
      EN_EX       <= state_nxt == EX && state != EX;
      EN_WB       <= state_nxt == WB && state != WB;
      RUNNING     <= state_nxt != HALT;
      HALT_CAUSE  <= cause_nxt;
      INSTR_CNT   <= INSTR_CNT + {15'd0, wb_done};
      step_mode   <= state == HALT ? STEP_REQ : step_mode;
      halt_lat    <= state_nxt == HALT ? 1'b0 : (state != HALT && HALT_REQ) ? 1'b1 : halt_lat;
      first_instr <= (state == HALT && exit_halt) ? 1'b1 : (wb_done && state_nxt == FT) ? 1'b0 : first_instr;
    end
  end
`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0] cyc;
  // active-cycle counter, cleared only by reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) cyc <= '0;
    else          cyc <= cyc + {31'd0, RUNNING};
  end
  assign CYCLE_CNT = cyc;
`else
  assign CYCLE_CNT = '0;
`endif
endmodule
